rx_sequencer: RTL and testbench

RX_SEQUENCER -- requirements
Module: rx_sequencer

---
 rtl/rx_seq_pkg.sv | 15 +
 rtl/rx_bit_timer.sv | 33 +++
 rtl/rx_sequencer.sv | 108 ++++++++++
 tb/tb_rx_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_seq_pkg.sv
// rtl/rx_seq_pkg.sv - shared types and defaults for the RX sequencer
package rx_seq_pkg;

    localparam int DEFAULT_BIT_PERIOD = 10;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        LOAD      = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - per-bit cycle counter producing mid-bit and end-of-bit ticks
module rx_bit_timer
    import rx_seq_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign half_tick = enable && (cnt == HALF_LAST);
    assign full_tick = enable && (cnt == FULL_LAST);

    // clear has priority so every state entry starts the bit period at zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= full_tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rx_sequencer.sv
// rtl/rx_sequencer.sv - serial receive frame sequencer with status flags
module rx_sequencer
    import rx_seq_pkg::*;
#(
    parameter int BIT_PERIOD = DEFAULT_BIT_PERIOD,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic start_bit_detected,
    input  logic serial_in,
    input  logic data_read,
    output logic shift_strobe,
    output logic load_buffer,
    output logic data_ready,
    output logic framing_error,
    output logic overrun_error,
    output logic busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(DATA_BITS - 1);

    rx_state_t     state;
    rx_state_t     next_state;
    logic [BW-1:0] bit_cnt;
    logic          half_tick;
    logic          full_tick;
    logic          timer_en;
    logic          timer_clear;

    assign timer_en    = (state == START_CHK) || (state == DATA) || (state == STOP);
    assign timer_clear = (next_state != state);

    rx_bit_timer #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .enable   (timer_en),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_bit_detected) next_state = START_CHK;
            START_CHK: if (half_tick) next_state = serial_in ? IDLE : DATA;
            DATA:      if (full_tick && (bit_cnt == LAST_IDX)) next_state = STOP;
            STOP:      if (full_tick) next_state = serial_in ? LOAD : IDLE;
            LOAD:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_strobe = 1'b0;
        load_buffer  = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            DATA:    shift_strobe = full_tick;
            LOAD:    load_buffer = 1'b1;
            default: ;
        endcase
    end

    // a load in the same cycle as data_read keeps the new byte and leaves overrun alone
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (state == START_CHK && half_tick && !serial_in) begin
                bit_cnt       <= '0;
                framing_error <= 1'b0;
            end
            if (shift_strobe) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (state == STOP && full_tick && !serial_in) begin
                framing_error <= 1'b1;
            end
            if (load_buffer) begin
                data_ready <= 1'b1;
                if (data_ready && !data_read) begin
                    overrun_error <= 1'b1;
                end
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_sequencer.sv
// tb/tb_rx_sequencer.sv - directed self-checking bench for rx_sequencer
module tb_rx_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_bit_detected = 1'b0;
    logic serial_in = 1'b1;
    logic data_read = 1'b0;
    logic shift_strobe;
    logic load_buffer;
    logic data_ready;
    logic framing_error;
    logic overrun_error;
    logic busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] shreg = 8'h00;
    logic strobe_log [0:127];
    logic load_log   [0:127];
    logic busy_log   [0:127];
    logic dr_log     [0:127];
    logic fe_log     [0:127];
    logic oe_log     [0:127];

    always #5 clk = ~clk;

    rx_sequencer #(
        .BIT_PERIOD(10),
        .DATA_BITS (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_bit_detected(start_bit_detected),
        .serial_in         (serial_in),
        .data_read         (data_read),
        .shift_strobe      (shift_strobe),
        .load_buffer       (load_buffer),
        .data_ready        (data_ready),
        .framing_error     (framing_error),
        .overrun_error     (overrun_error),
        .busy              (busy)
    );

    // receiving shift register, LSB first
    always @(posedge clk) begin
        if (shift_strobe) shreg <= {serial_in, shreg[7:1]};
    end

    function automatic logic line_at(int c, logic [7:0] d, logic stop_b, int high_from);
        if (c >= high_from) return 1'b1;
        if (c < 10) return 1'b0;
        if (c < 90) return d[(c - 10) / 10];
        if (c < 100) return stop_b;
        return 1'b1;
    endfunction

    // expected strobes at 15, 25, ..., 85 only
    function automatic int strobe_errs(int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (strobe_log[c] !== ((c >= 15) && (c <= 85) && ((c - 15) % 10 == 0))) n++;
        end
        return n;
    endfunction

    function automatic int load_errs(int ncyc, int at);
        int n = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (load_log[c] !== (c == at)) n++;
        end
        return n;
    endfunction

    function automatic int strobe_count(int ncyc);
        int n = 0;
        for (int c = 0; c < ncyc; c++) if (strobe_log[c] === 1'b1) n++;
        return n;
    endfunction

    // cycle 0 is the start_bit_detected cycle; entered and left at posedge+1
    task automatic drive_frame(input logic [7:0] d, input logic stop_b, input int high_from,
                               input int rst_cyc, input int extra_cyc, input int read_cyc,
                               input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            start_bit_detected = (c == 0) || (c == extra_cyc);
            serial_in          = line_at(c, d, stop_b, high_from);
            rst                = (c == rst_cyc);
            data_read          = (c == read_cyc);
            @(negedge clk);
            strobe_log[c] = shift_strobe;
            load_log[c]   = load_buffer;
            busy_log[c]   = busy;
            dr_log[c]     = data_ready;
            fe_log[c]     = framing_error;
            oe_log[c]     = overrun_error;
            @(posedge clk);
            #1;
        end
        start_bit_detected = 1'b0;
        serial_in          = 1'b1;
        rst                = 1'b0;
        data_read          = 1'b0;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(posedge clk);
        #1;
        data_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_bit_detected = 1'b1;
        serial_in = 1'b0;
        data_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({shift_strobe, load_buffer, data_ready, framing_error, overrun_error, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {shift_strobe, load_buffer, data_ready, framing_error, overrun_error, busy});
        end
        rst = 1'b0;
        start_bit_detected = 1'b0;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_clean_frame();
        drive_frame(8'hA5, 1'b1, 1000, -1, -1, -1, 100);
        checks++;
        if (strobe_errs(100) !== 0) begin
            errors++;
            $display("FAIL clean_strobe_timing: got %0d bad cycles expected 0", strobe_errs(100));
        end
        checks++;
        if (load_errs(100, 96) !== 0) begin
            errors++;
            $display("FAIL clean_load_timing: got %0d bad cycles expected 0", load_errs(100, 96));
        end
        checks++;
        if (shreg !== 8'hA5) begin
            errors++;
            $display("FAIL clean_shreg: got %h expected a5", shreg);
        end
        checks++;
        if ({dr_log[97], fe_log[97], oe_log[97]} !== 3'b100) begin
            errors++;
            $display("FAIL clean_flags: got %b expected 100", {dr_log[97], fe_log[97], oe_log[97]});
        end
        checks++;
        if ({busy_log[0], busy_log[1], busy_log[96], busy_log[97]} !== 4'b0110) begin
            errors++;
            $display("FAIL clean_busy: got %b expected 0110",
                     {busy_log[0], busy_log[1], busy_log[96], busy_log[97]});
        end
    endtask

    task automatic test_glitch();
        drive_frame(8'hFF, 1'b1, 5, -1, -1, -1, 30);
        checks++;
        if ({busy_log[5], busy_log[6]} !== 2'b10) begin
            errors++;
            $display("FAIL glitch_busy: got %b expected 10", {busy_log[5], busy_log[6]});
        end
        checks++;
        if (strobe_count(30) !== 0 || load_errs(30, -1) !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: got strobes=%0d bad_loads=%0d expected 0 0",
                     strobe_count(30), load_errs(30, -1));
        end
        checks++;
        if ({dr_log[29], fe_log[29], oe_log[29]} !== 3'b100) begin
            errors++;
            $display("FAIL glitch_flags: got %b expected 100", {dr_log[29], fe_log[29], oe_log[29]});
        end
        pulse_read();
        checks++;
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_clears_ready: got %b expected 0", data_ready);
        end
    endtask

    task automatic test_framing();
        drive_frame(8'h3C, 1'b0, 1000, -1, -1, -1, 100);
        checks++;
        if (strobe_errs(100) !== 0) begin
            errors++;
            $display("FAIL frame_err_strobes: got %0d bad cycles expected 0", strobe_errs(100));
        end
        checks++;
        if (load_errs(100, -1) !== 0) begin
            errors++;
            $display("FAIL frame_err_no_load: got %0d bad cycles expected 0", load_errs(100, -1));
        end
        checks++;
        if ({fe_log[95], fe_log[96], busy_log[96], dr_log[99]} !== 4'b0100) begin
            errors++;
            $display("FAIL frame_err_flags: got %b expected 0100",
                     {fe_log[95], fe_log[96], busy_log[96], dr_log[99]});
        end
        drive_frame(8'h5A, 1'b1, 1000, -1, -1, -1, 100);
        checks++;
        if ({fe_log[5], fe_log[6]} !== 2'b10) begin
            errors++;
            $display("FAIL frame_err_clear: got %b expected 10", {fe_log[5], fe_log[6]});
        end
        checks++;
        if (load_errs(100, 96) !== 0 || shreg !== 8'h5A) begin
            errors++;
            $display("FAIL frame_recover: got bad_loads=%0d shreg=%h expected 0 5a",
                     load_errs(100, 96), shreg);
        end
    endtask

    task automatic test_overrun();
        drive_frame(8'hC3, 1'b1, 1000, -1, -1, -1, 100);
        checks++;
        if ({oe_log[96], oe_log[97], dr_log[97]} !== 3'b011) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 011", {oe_log[96], oe_log[97], dr_log[97]});
        end
        drive_frame(8'h11, 1'b1, 1000, -1, -1, 96, 100);
        checks++;
        if ({dr_log[97], oe_log[97]} !== 2'b11) begin
            errors++;
            $display("FAIL overrun_hold_on_load_read: got %b expected 11", {dr_log[97], oe_log[97]});
        end
        pulse_read();
        checks++;
        if ({data_ready, overrun_error} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_read_clear: got %b expected 00", {data_ready, overrun_error});
        end
        drive_frame(8'h22, 1'b1, 1000, -1, -1, -1, 100);
        drive_frame(8'h44, 1'b1, 1000, -1, -1, 96, 100);
        checks++;
        if ({dr_log[97], oe_log[97]} !== 2'b10) begin
            errors++;
            $display("FAIL read_in_load_cycle: got %b expected 10", {dr_log[97], oe_log[97]});
        end
    endtask

    task automatic test_reset_midframe();
        drive_frame(8'hFF, 1'b1, 1000, 40, -1, -1, 50);
        checks++;
        if (busy_log[40] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before: got %b expected 1", busy_log[40]);
        end
        checks++;
        if ({strobe_log[41], load_log[41], dr_log[41], fe_log[41], oe_log[41], busy_log[41]} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 000000",
                     {strobe_log[41], load_log[41], dr_log[41], fe_log[41], oe_log[41], busy_log[41]});
        end
        checks++;
        if (load_errs(50, -1) !== 0) begin
            errors++;
            $display("FAIL midreset_no_load: got %0d bad cycles expected 0", load_errs(50, -1));
        end
        drive_frame(8'h96, 1'b1, 1000, -1, -1, -1, 100);
        checks++;
        if (load_errs(100, 96) !== 0 || shreg !== 8'h96 || oe_log[97] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next_frame: got bad_loads=%0d shreg=%h oe=%b expected 0 96 0",
                     load_errs(100, 96), shreg, oe_log[97]);
        end
    endtask

    task automatic test_ignore_start();
        pulse_read();
        drive_frame(8'hA5, 1'b1, 1000, -1, 30, -1, 100);
        checks++;
        if (strobe_errs(100) !== 0 || load_errs(100, 96) !== 0) begin
            errors++;
            $display("FAIL ignore_start_timing: got bad_strobes=%0d bad_loads=%0d expected 0 0",
                     strobe_errs(100), load_errs(100, 96));
        end
        checks++;
        if (shreg !== 8'hA5 || oe_log[97] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_data: got shreg=%h oe=%b expected a5 0", shreg, oe_log[97]);
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_ignore_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
